tart_ddr_capture_ctrl: RTL and testbench

Sequences one IDDR2 antenna-capture primitive. Holds it in reset, enables it, then measures where signal transitions fall between the two DDR samples (Q0 on C0, Q1 on C1) over a fixed window. It selects the more settled sample and streams one bit per clock to the correlator front-end. Retraining on request keeps the data stream running throughout.

---
 rtl/tart_ddr_pkg.sv | 16 +
 rtl/tart_ddr_capture_ctrl_if.sv | 29 ++
 rtl/tart_edge_count.sv | 39 +++
 rtl/tart_ddr_capture_ctrl.sv | 135 +++++++++++++
 tb/tb_tart_ddr_capture_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/tart_ddr_pkg.sv
// Shared types for the TART IDDR2 capture controller: FSM states and sample-select encoding.
package tart_ddr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      SETTLE,
      MEASURE,
      DECIDE,
      RUN
   } state_t;

   localparam logic SEL_Q0 = 1'b0;
   localparam logic SEL_Q1 = 1'b1;

endpackage

// File: rtl/tart_ddr_capture_ctrl_if.sv
// Control/data bundle between the capture controller and its driver (IDDR2 side plus correlator side).
interface tart_ddr_capture_ctrl_if #(
   parameter int unsigned WIN_LOG2 = 10
);

   logic                enable_i;
   logic                retrain_i;
   logic                q0_i;
   logic                q1_i;
   logic                iddr_rst_o;
   logic                iddr_ce_o;
   logic                data_o;
   logic                valid_o;
   logic                sel_o;
   logic                locked_o;
   logic [WIN_LOG2:0]   cnt01_o;
   logic [WIN_LOG2:0]   cnt10_o;

   modport master (
      output enable_i, retrain_i, q0_i, q1_i,
      input  iddr_rst_o, iddr_ce_o, data_o, valid_o, sel_o, locked_o, cnt01_o, cnt10_o
   );

   modport slave (
      input  enable_i, retrain_i, q0_i, q1_i,
      output iddr_rst_o, iddr_ce_o, data_o, valid_o, sel_o, locked_o, cnt01_o, cnt10_o
   );

endinterface

// File: rtl/tart_edge_count.sv
// Windowed pair of transition counters: intra-cycle (q0 vs q1) and cross-cycle (previous q1 vs q0).
module tart_edge_count #(
   parameter int unsigned WIN_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic                q0,
   input  logic                q1,
   output logic [WIN_LOG2:0]   cnt01,
   output logic [WIN_LOG2:0]   cnt10,
   output logic                done_c
);

   localparam int unsigned CNT_W = WIN_LOG2 + 1;
   localparam int unsigned IDX_W = WIN_LOG2;

   logic [IDX_W-1:0] idx;
   logic             q1_prev;

   // 2^WIN_LOG2 samples max per window, so CNT_W bits never wrap
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt01   <= '0;
         cnt10   <= '0;
         idx     <= '0;
         q1_prev <= 1'b0;
      end else if (en) begin
         cnt01   <= cnt01 + CNT_W'(q0 ^ q1);
         cnt10   <= cnt10 + CNT_W'(q1_prev ^ q0);
         q1_prev <= q1;
         idx     <= idx + IDX_W'(1);
      end
   end

   assign done_c = en && (idx == '1);

endmodule

// File: rtl/tart_ddr_capture_ctrl.sv
// Sequences one IDDR2 capture primitive: reset, enable, measure edge placement, pick the settled sample, stream it.
module tart_ddr_capture_ctrl
   import tart_ddr_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned WIN_LOG2      = 10,
   parameter int unsigned HYST          = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   tart_ddr_capture_ctrl_if.slave   bus
);

   localparam int unsigned CNT_W   = WIN_LOG2 + 1;
   localparam int unsigned CYC_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
   localparam int unsigned CMP_W   = 32;

   state_t             state;
   logic [CYC_W-1:0]   cyc;
   logic               meas_en;
   logic               meas_clr;
   logic               done_c;
   logic [CNT_W-1:0]   win01;
   logic [CNT_W-1:0]   win10;
   logic [CMP_W-1:0]   c01_w;
   logic [CMP_W-1:0]   c10_w;
   logic               new_sel_c;

   assign meas_en  = bus.enable_i && (state == MEASURE);
   assign meas_clr = bus.enable_i &&
                     (((state == SETTLE) && (cyc == CYC_W'(SETTLE_CYCLES - 1))) ||
                      ((state == RUN) && bus.retrain_i));

   tart_edge_count #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_edge_count (
      .clk    (clk_i),
      .rst    (rst_i),
      .clr    (meas_clr),
      .en     (meas_en),
      .q0     (bus.q0_i),
      .q1     (bus.q1_i),
      .cnt01  (win01),
      .cnt10  (win10),
      .done_c (done_c)
   );

   assign c01_w = CMP_W'(win01);
   assign c10_w = CMP_W'(win10);

   // First lock picks the quieter sample outright; later decisions need a margin beyond HYST to flip
   always_comb begin
      new_sel_c = bus.sel_o;
      if (!bus.locked_o) begin
         new_sel_c = (c10_w > c01_w) ? SEL_Q1 : SEL_Q0;
      end else if (bus.sel_o == SEL_Q0) begin
         new_sel_c = (c10_w > c01_w + CMP_W'(HYST)) ? SEL_Q1 : SEL_Q0;
      end else begin
         new_sel_c = (c01_w > c10_w + CMP_W'(HYST)) ? SEL_Q0 : SEL_Q1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         cyc            <= '0;
         bus.iddr_rst_o <= 1'b1;
         bus.iddr_ce_o  <= 1'b0;
         bus.data_o     <= 1'b0;
         bus.valid_o    <= 1'b0;
         bus.sel_o      <= SEL_Q0;
         bus.locked_o   <= 1'b0;
         bus.cnt01_o    <= '0;
         bus.cnt10_o    <= '0;
      end else if (!bus.enable_i) begin
         state          <= IDLE;
         cyc            <= '0;
         bus.iddr_rst_o <= 1'b1;
         bus.iddr_ce_o  <= 1'b0;
         bus.data_o     <= 1'b0;
         bus.valid_o    <= 1'b0;
         bus.sel_o      <= SEL_Q0;
         bus.locked_o   <= 1'b0;
      end else begin
         // once locked the stream never pauses, including across a retrain window
         bus.valid_o <= bus.locked_o;
         bus.data_o  <= bus.locked_o && ((bus.sel_o == SEL_Q1) ? bus.q1_i : bus.q0_i);
         case (state)
            IDLE: begin
               state <= RESET;
               cyc   <= '0;
            end
            RESET: begin
               if (cyc == CYC_W'(RST_CYCLES - 1)) begin
                  state          <= SETTLE;
                  cyc            <= '0;
                  bus.iddr_rst_o <= 1'b0;
                  bus.iddr_ce_o  <= 1'b1;
               end else begin
                  cyc <= cyc + CYC_W'(1);
               end
            end
            SETTLE: begin
               if (cyc == CYC_W'(SETTLE_CYCLES - 1)) begin
                  state <= MEASURE;
                  cyc   <= '0;
               end else begin
                  cyc <= cyc + CYC_W'(1);
               end
            end
            MEASURE: begin
               if (done_c) begin
                  state <= DECIDE;
               end
            end
            DECIDE: begin
               bus.sel_o    <= new_sel_c;
               bus.cnt01_o  <= win01;
               bus.cnt10_o  <= win10;
               bus.locked_o <= 1'b1;
               state        <= RUN;
            end
            RUN: begin
               if (bus.retrain_i) begin
                  state <= MEASURE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tart_ddr_capture_ctrl.sv
// Self-checking bench for tart_ddr_capture_ctrl: directed phases plus random stream against a timeline model.
module tb_tart_ddr_capture_ctrl;

   localparam int W     = 4;
   localparam int NWIN  = 16;
   localparam int HYST  = 4;
   localparam int RSTC  = 8;
   localparam int SETC  = 2;
   localparam int WS0   = 1 + RSTC + SETC + 1;   // cycle index of first window sample after enable
   localparam int LOCKN = WS0 + NWIN;            // cycle index at which locked_o first reads 1

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tart_ddr_capture_ctrl_if #(.WIN_LOG2(W)) dif();

   tart_ddr_capture_ctrl #(
      .RST_CYCLES    (RSTC),
      .SETTLE_CYCLES (SETC),
      .WIN_LOG2      (W),
      .HYST          (HYST)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (dif)
   );

   int total = 0;
   int bad   = 0;

   // reference model: elapsed enabled cycles, active window span, expected decision outputs
   int n  = 0;
   int ws = -100;
   int dn = -1;
   int c01, c10;
   bit qp;
   bit e_locked = 1'b0;
   bit e_sel    = 1'b0;
   int e_c01    = 0;
   int e_c10    = 0;

   bit wq0 [NWIN];
   bit wq1 [NWIN];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock: drive inputs, advance model by spec rules, check every output
   task automatic cyc(input bit en, input bit q0v, input bit q1v, input bit ret);
      bit pl, ps;
      pl = e_locked;
      ps = e_sel;
      dif.enable_i  = en;
      dif.q0_i      = q0v;
      dif.q1_i      = q1v;
      dif.retrain_i = ret;
      if (!en) begin
         n = 0; e_locked = 1'b0; e_sel = 1'b0; dn = -1; ws = -100;
      end else begin
         n++;
         if (n == 1) begin
            ws = WS0; dn = WS0 + NWIN;
         end else if (ret && pl && n > dn) begin
            ws = n + 1; dn = ws + NWIN;
         end
         if (n >= ws && n < ws + NWIN) begin
            if (n == ws) begin c01 = 0; c10 = 0; qp = 1'b0; end
            c01 += int'(q0v != q1v);
            c10 += int'(qp != q0v);
            qp = q1v;
         end
         if (n == dn) begin
            if (!pl)        e_sel = (c10 > c01);
            else if (!e_sel) e_sel = (c10 > c01 + HYST);
            else            e_sel = !(c01 > c10 + HYST);
            e_c01 = c01; e_c10 = c10; e_locked = 1'b1;
         end
      end
      @(negedge clk);
      chk("iddr_rst", 32'(dif.iddr_rst_o), 32'(!en || n <= RSTC));
      chk("iddr_ce",  32'(dif.iddr_ce_o),  32'(en && n > RSTC));
      chk("valid",    32'(dif.valid_o),    32'(en && pl));
      chk("data",     32'(dif.data_o),     32'(en && pl && (ps ? q1v : q0v)));
      chk("locked",   32'(dif.locked_o),   32'(e_locked));
      chk("sel",      32'(dif.sel_o),      32'(e_sel));
      chk("cnt01",    32'(dif.cnt01_o),    32'(e_c01));
      chk("cnt10",    32'(dif.cnt10_o),    32'(e_c10));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      dif.enable_i = 1'b0; dif.retrain_i = 1'b0; dif.q0_i = 1'b0; dif.q1_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n = 0; e_locked = 1'b0; e_sel = 1'b0; dn = -1; ws = -100; e_c01 = 0; e_c10 = 0;
      chk("rst_iddr_rst", 32'(dif.iddr_rst_o), 32'(1));
      chk("rst_ce",       32'(dif.iddr_ce_o),  32'(0));
      chk("rst_valid",    32'(dif.valid_o),    32'(0));
      chk("rst_data",     32'(dif.data_o),     32'(0));
      chk("rst_locked",   32'(dif.locked_o),   32'(0));
      chk("rst_sel",      32'(dif.sel_o),      32'(0));
      chk("rst_cnt01",    32'(dif.cnt01_o),    32'(0));
      chk("rst_cnt10",    32'(dif.cnt10_o),    32'(0));
      rst = 1'b0;
   endtask

   // search for a random window whose transition counts hit the requested totals
   task automatic find_win(input int t01, input int t10);
      bit ok, p;
      int a, b;
      ok = 1'b0;
      for (int tr = 0; tr < 20000 && !ok; tr++) begin
         a = 0; b = 0; p = 1'b0;
         for (int i = 0; i < NWIN; i++) begin
            wq0[i] = 1'($urandom_range(0, 1));
            wq1[i] = 1'($urandom_range(0, 1));
            a += int'(wq0[i] != wq1[i]);
            b += int'(p != wq0[i]);
            p = wq1[i];
         end
         ok = (a == t01) && (b == t10);
      end
      chk("find_win", 32'(ok), 32'(1));
   endtask

   task automatic retrain_with(input int t01, input int t10);
      find_win(t01, t10);
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < NWIN; i++) cyc(1'b1, wq0[i], wq1[i], 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      chk("retrain_cnt01", 32'(dif.cnt01_o), 32'(t01));
      chk("retrain_cnt10", 32'(dif.cnt10_o), 32'(t10));
   endtask

   initial begin
      int rh, lockn;
      bit qv;
      do_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // bring-up with toggling q0=q1, retrain pulsed during SETTLE
      rh = 0; lockn = 0;
      for (int k = 0; k < 32; k++) begin
         qv = ((n + 1) % 2 == 0);
         cyc(1'b1, qv, qv, (n + 1 == RSTC + 2));
         if (dif.iddr_rst_o) rh++;
         if (dif.locked_o && lockn == 0) lockn = n;
      end
      chk("bringup_rst_cycles", 32'(rh), 32'(RSTC));
      chk("bringup_lock_cycle", 32'(lockn), 32'(LOCKN));
      chk("toggle_cnt10", 32'(dif.cnt10_o), 32'(16));
      chk("toggle_cnt01", 32'(dif.cnt01_o), 32'(0));
      chk("toggle_sel",   32'(dif.sel_o),   32'(1));

      for (int k = 0; k < 20; k++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

      // hysteresis: margin of 3 holds Q1, margin of 5 flips to Q0
      retrain_with(10, 7);
      chk("hyst_hold_sel", 32'(dif.sel_o), 32'(1));
      retrain_with(12, 7);
      chk("hyst_flip_sel", 32'(dif.sel_o), 32'(0));

      // abort mid-MEASURE, then full bring-up on a quiet input (tie)
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 15; k++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("abort_locked", 32'(dif.locked_o), 32'(0));
      chk("abort_ce",     32'(dif.iddr_ce_o), 32'(0));
      rh = 0; lockn = 0;
      for (int k = 0; k < 32; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         if (dif.iddr_rst_o) rh++;
         if (dif.locked_o && lockn == 0) lockn = n;
      end
      chk("reenable_rst_cycles", 32'(rh), 32'(RSTC));
      chk("reenable_lock_cycle", 32'(lockn), 32'(LOCKN));
      chk("tie_cnt01", 32'(dif.cnt01_o), 32'(0));
      chk("tie_cnt10", 32'(dif.cnt10_o), 32'(0));
      chk("tie_sel",   32'(dif.sel_o),   32'(0));

      // random stream with sporadic retrains, occasionally biased toward intra-cycle edges
      for (int k = 0; k < 300; k++) begin
         bit a, b;
         a = 1'($urandom_range(0, 1));
         b = ((k / 40) % 2 == 1) ? ~a : 1'($urandom_range(0, 1));
         cyc(1'b1, a, b, ($urandom_range(0, 7) == 0));
      end

      // synchronous reset while running
      do_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
